// File: rtl/fixed_to_fp.sv
// fixed_to_fp: signed fixed-point (WORD_LENGTH, FRAC_BITS) to IEEE-754 single.
// Ports: clk, reset (sync high), clk_en, start, dataa in; done pulse, result out.
// Conversion is exact. Normalisation shifts one bit per cycle by default.
// Define FIXED_TO_FP_BARREL_EN to normalise in one cycle with an LZC + barrel shift.
module fixed_to_fp #(
  parameter int WORD_LENGTH = 21,
  parameter int FRAC_BITS   = 19
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] dataa,
  output logic                   done,
  output logic [31:0]            result
);

  localparam int W     = WORD_LENGTH;
  localparam int EBIAS = 127 + W - 1 - FRAC_BITS;
  localparam int PAD   = 24 - W;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    DONE
  } state_t;

  state_t       state_q;
  logic         sign_q;
  logic [W-1:0] mag_q;
  logic [4:0]   lz_q;
  logic         done_q;
  logic [31:0]  result_q;

  // Unsigned magnitude; the most negative input maps to 2^(W-1).
  logic [W-1:0] abs_d;
  assign abs_d = dataa[W-1] ? (~dataa + ONE) : dataa;

  // Normalised magnitude and its shift count as seen by the pack logic.
  logic [W-1:0] nmag_d;
  logic [4:0]   nlz_d;

`ifdef FIXED_TO_FP_BARREL_EN
  always_comb begin
    nlz_d = '0;
    for (int i = 0; i < W; i++) begin
      if (mag_q[i]) nlz_d = 5'(W - 1 - i);
    end
    nmag_d = mag_q << nlz_d;
  end
`else
  assign nmag_d = mag_q;
  assign nlz_d  = lz_q;
`endif

  // Hidden bit dropped, remaining bits left-aligned in the 23-bit field.
  logic [22:0] man_d;
  logic [7:0]  exp_d;
  logic [31:0] res_d;
  assign man_d = 23'(nmag_d[W-2:0]) << PAD;
  assign exp_d = 8'(EBIAS - int'(nlz_d));
  assign res_d = {sign_q, exp_d, man_d};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mag_q    <= '0;
      lz_q     <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else if (clk_en) begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sign_q  <= dataa[W-1];
            mag_q   <= abs_d;
            lz_q    <= '0;
            state_q <= NORM;
          end
        end
        NORM: begin
          if (mag_q == '0) begin
            result_q <= '0;
            state_q  <= DONE;
          end else if (nmag_d[W-1]) begin
            result_q <= res_d;
            mag_q    <= nmag_d;
            lz_q     <= nlz_d;
            state_q  <= DONE;
          end else begin
            mag_q <= mag_q << 1;
            lz_q  <= lz_q + 5'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule
